// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready request in, APB setup/access out,
// one-cycle response strobe back, with an optional wait-state timeout.
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready or timeout
module apb_master #(
  parameter int addr_w  = 5,
  parameter int data_w  = 32,
  parameter int tmo_cyc = 16
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [addr_w-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [data_w-1:0] req_wd_i,
  output logic              resp_valid_o,
  output logic [data_w-1:0] resp_rd_o,
  output logic              resp_err_o,
  output logic [addr_w-1:0] paddr_o,
  output logic [data_w-1:0] pwdata_o,
  output logic              pwrite_o,
  output logic              psel_o,
  output logic              penable_o,
  input  logic [data_w-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int CNT_W    = (tmo_cyc < 1) ? 1 : $clog2(tmo_cyc + 1);
  localparam int TMO_LAST = (tmo_cyc < 1) ? 0 : tmo_cyc - 1;
  localparam bit TMO_EN   = (tmo_cyc != 0);

  logic [1:0]        state_q, state_d;
  logic [addr_w-1:0] paddr_q, paddr_d;
  logic [data_w-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              resp_valid_q, resp_valid_d;
  logic [data_w-1:0] resp_rd_q, resp_rd_d;
  logic              resp_err_q, resp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    resp_valid_d = 1'b0;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          paddr_d   = req_addr_i;
          pwrite_d  = req_we_i;
          pwdata_d  = req_wd_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over a timeout expiring in the same cycle
        if (pready_i) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = pslverr_i;
          resp_rd_d    = pwrite_q ? '0 : prdata_i;
          state_d      = IDLE;
        end else if (TMO_EN) begin
          if (cnt_q == CNT_W'(TMO_LAST)) begin
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rd_d    = '0;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q      <= IDLE;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign pwrite_o     = pwrite_q;
  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rd_o    = resp_rd_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: u_dut uses a 4-cycle timeout, u_dut0 has the
// timeout disabled and only sees traffic during its own test.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        req_valid = 1'b0, req_valid0 = 1'b0;
  logic [4:0]  req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wd = '0;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pready0 = 1'b1;
  logic        pslverr = 1'b0;

  logic        req_ready, resp_valid, resp_err, pwrite, psel, penable;
  logic [31:0] resp_rd, pwdata;
  logic [4:0]  paddr;
  logic        req_ready0, resp_valid0, resp_err0, pwrite0, psel0, penable0;
  logic [31:0] resp_rd0, pwdata0;
  logic [4:0]  paddr0;

  int n_vec = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb_master #(.addr_w(5), .data_w(32), .tmo_cyc(4)) u_dut (
    .pclk_i(pclk), .preset_i(preset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_wd_i(req_wd),
    .resp_valid_o(resp_valid), .resp_rd_o(resp_rd), .resp_err_o(resp_err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
    .psel_o(psel), .penable_o(penable),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  apb_master #(.addr_w(5), .data_w(32), .tmo_cyc(0)) u_dut0 (
    .pclk_i(pclk), .preset_i(preset),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_wd_i(req_wd),
    .resp_valid_o(resp_valid0), .resp_rd_o(resp_rd0), .resp_err_o(resp_err0),
    .paddr_o(paddr0), .pwdata_o(pwdata0), .pwrite_o(pwrite0),
    .psel_o(psel0), .penable_o(penable0),
    .prdata_i(prdata), .pready_i(pready0), .pslverr_i(pslverr)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic we, input logic [31:0] wd);
    req_addr  = a;
    req_we    = we;
    req_wd    = wd;
    req_valid = 1'b1;
  endtask

  initial begin
    int n;
    logic bad;

    // reset state
    #2;
    check_vec("rst_psel", {31'd0, psel}, 32'd0);
    check_vec("rst_penable", {31'd0, penable}, 32'd0);
    check_vec("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_vec("rst_resp_rd", resp_rd, 32'd0);
    check_vec("rst_paddr", {27'd0, paddr}, 32'd0);
    check_vec("rst_req_ready", {31'd0, req_ready}, 32'd1);
    tick(); tick();
    preset = 1'b0;
    tick();

    // zero-wait write
    pready = 1'b1;
    issue(5'h04, 1'b1, 32'h0000_00A5);
    tick();
    req_valid = 1'b0;
    check_vec("wr_t1_sel_en", {30'd0, psel, penable}, 32'b10);
    check_vec("wr_t1_paddr", {27'd0, paddr}, 32'h04);
    check_vec("wr_t1_pwdata", pwdata, 32'hA5);
    check_vec("wr_t1_pwrite", {31'd0, pwrite}, 32'd1);
    check_vec("wr_t1_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check_vec("wr_t2_sel_en", {30'd0, psel, penable}, 32'b11);
    check_vec("wr_t2_paddr", {27'd0, paddr}, 32'h04);
    check_vec("wr_t2_pwdata", pwdata, 32'hA5);
    tick();
    check_vec("wr_t3_sel_en", {30'd0, psel, penable}, 32'b00);
    check_vec("wr_t3_resp", {30'd0, resp_valid, resp_err}, 32'b10);
    check_vec("wr_t3_rd", resp_rd, 32'd0);
    check_vec("wr_t3_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check_vec("wr_t4_pulse", {31'd0, resp_valid}, 32'd0);

    // read with two wait cycles
    pready = 1'b0;
    issue(5'h08, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    n = 0;
    if (psel) n++;
    tick(); if (psel) n++;
    tick(); if (psel) n++;
    check_vec("rd_wait_noresp", {31'd0, resp_valid}, 32'd0);
    tick(); if (psel) n++;
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    tick(); if (psel) n++;
    check_vec("rd_psel_cycles", n, 32'd4);
    check_vec("rd_resp_valid", {31'd0, resp_valid}, 32'd1);
    check_vec("rd_resp_rd", resp_rd, 32'hDEAD_BEEF);
    check_vec("rd_resp_err", {31'd0, resp_err}, 32'd0);
    tick();

    // read with slave error, then a held request accepted in the response cycle
    pslverr = 1'b1;
    prdata  = 32'h1234_5678;
    issue(5'h10, 1'b0, 32'h0);
    tick();
    issue(5'h1F, 1'b1, 32'h0000_5A5A);
    tick();
    check_vec("b2b_held_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check_vec("err_resp", {30'd0, resp_valid, resp_err}, 32'b11);
    check_vec("err_resp_rd", resp_rd, 32'h1234_5678);
    check_vec("err_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    pslverr   = 1'b0;
    check_vec("b2b_setup", {30'd0, psel, penable}, 32'b10);
    check_vec("b2b_paddr", {27'd0, paddr}, 32'h1F);
    check_vec("b2b_err_hold", {30'd0, resp_valid, resp_err}, 32'b01);
    tick();
    tick();
    check_vec("b2b_resp", {30'd0, resp_valid, resp_err}, 32'b10);
    check_vec("b2b_resp_rd", resp_rd, 32'd0);
    tick();

    // timeout with pready held low
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    issue(5'h03, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    n = 0;
    while (psel && penable && n < 20) begin
      n++;
      tick();
    end
    check_vec("tmo_access_cycles", n, 32'd4);
    check_vec("tmo_sel_en", {30'd0, psel, penable}, 32'b00);
    check_vec("tmo_resp", {30'd0, resp_valid, resp_err}, 32'b11);
    check_vec("tmo_resp_rd", resp_rd, 32'd0);
    tick();

    // pready rises on the 4th access cycle: completes normally
    prdata = 32'h0BAD_F00D;
    issue(5'h03, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check_vec("tmo_edge_a4", {30'd0, psel, penable}, 32'b11);
    pready = 1'b1;
    tick();
    check_vec("tmo_edge_resp", {30'd0, resp_valid, resp_err}, 32'b10);
    check_vec("tmo_edge_rd", resp_rd, 32'h0BAD_F00D);
    tick();

    // asynchronous reset in the middle of ACCESS
    pready = 1'b0;
    issue(5'h06, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    #2 preset = 1'b1;
    #1;
    check_vec("arst_sel_en", {30'd0, psel, penable}, 32'b00);
    check_vec("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    #2 preset = 1'b0;
    tick();
    check_vec("arst_ready", {31'd0, req_ready}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid || psel) bad = 1'b1;
      tick();
    end
    check_vec("arst_no_spurious", {31'd0, bad}, 32'd0);

    // timeout disabled: 1000 wait cycles, then normal completion
    pready0 = 1'b0;
    req_addr = 5'h07;
    req_we   = 1'b0;
    req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (resp_valid0 || !psel0 || !penable0) bad = 1'b1;
      tick();
    end
    check_vec("notmo_hold", {31'd0, bad}, 32'd0);
    pready0 = 1'b1;
    prdata  = 32'hCAFE_0001;
    tick();
    check_vec("notmo_resp", {30'd0, resp_valid0, resp_err0}, 32'b10);
    check_vec("notmo_rd", resp_rd0, 32'hCAFE_0001);
    check_vec("notmo_sel_en", {30'd0, psel0, penable0}, 32'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
